// File: rtl/xeng_acc_sched_if.sv
// Control/status bundle between the X-engine accumulation scheduler
// and its controller.
interface xeng_acc_sched_if;
    logic        start;
    logic        stop;
    logic [15:0] acc_len;
    logic        data_vld;
    logic        bl_sync;
    logic        bl_en;
    logic        acc_first;
    logic        acc_last;
    logic        dump;
    logic [31:0] acc_cnt;
    logic        busy;

    modport master (
        output start, stop, acc_len, data_vld,
        input  bl_sync, bl_en, acc_first, acc_last, dump, acc_cnt, busy
    );

    modport slave (
        input  start, stop, acc_len, data_vld,
        output bl_sync, bl_en, acc_first, acc_last, dump, acc_cnt, busy
    );
endinterface

// File: rtl/xeng_acc_sched.sv
// Accumulation scheduler: drives the baseline-order generator and marks
// first/last triangles and the dump cycle of each accumulation.
module xeng_acc_sched #(
    parameter int N_ANTS = 16
) (
    input logic              clk,
    input logic              rst,
    xeng_acc_sched_if.slave  bus
);
    localparam int TRI_LEN = N_ANTS * (N_ANTS / 2 + 1);
    localparam int CW      = $clog2(TRI_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [15:0] tri_q, tri_d;
    logic [15:0] len_q, len_d;
    logic        pend_q, pend_d;
    logic [31:0] acc_q, acc_d;

    logic run, en, cyc_end, tri_end, dump_w;

    assign run     = (state_q == RUN);
    assign en      = run & bus.data_vld;
    assign cyc_end = (cyc_q == CW'(TRI_LEN - 1));
    assign tri_end = (tri_q == len_q - 16'd1);
    assign dump_w  = en & cyc_end & tri_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            tri_q   <= '0;
            len_q   <= 16'd1;
            pend_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            tri_q   <= tri_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tri_d   = tri_q;
        len_d   = len_q;
        pend_d  = pend_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SYNC;
                    len_d   = (bus.acc_len == 16'd0) ? 16'd1 : bus.acc_len;
                    acc_d   = '0;
                    cyc_d   = '0;
                    tri_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            SYNC: state_d = RUN;
            RUN: begin
                if (bus.stop)
                    pend_d = 1'b1;
                if (en) begin
                    cyc_d = cyc_end ? '0 : cyc_q + 1'b1;
                    if (cyc_end)
                        tri_d = tri_end ? 16'd0 : tri_q + 16'd1;
                end
                // A stop arriving on the dump cycle still ends this accumulation
                if (dump_w) begin
                    acc_d  = acc_q + 32'd1;
                    pend_d = 1'b0;
                    if (pend_q | bus.stop)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bl_sync   = (state_q == SYNC);
    assign bus.bl_en     = en;
    assign bus.acc_first = run & (tri_q == 16'd0);
    assign bus.acc_last  = run & tri_end;
    assign bus.dump      = dump_w;
    assign bus.acc_cnt   = acc_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_xeng_acc_sched.sv
// Directed bench for xeng_acc_sched: vector table plus multi-cycle
// accumulation, stop and reset sequences at N_ANTS=16.
module tb_xeng_acc_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    xeng_acc_sched_if bus();

    xeng_acc_sched #(.N_ANTS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic        vld;
        logic [15:0] len;
        logic        sync;
        logic        en;
        logic        first;
        logic        last;
        logic        dump;
        logic        busy;
        logic [31:0] acc;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic p,
                         input logic [15:0] l, input logic v);
        @(negedge clk);
        bus.start    = s;
        bus.stop     = p;
        bus.acc_len  = l;
        bus.data_vld = v;
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.acc_len  = 16'd0;
        bus.data_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start in IDLE, then step through the SYNC cycle checking it.
    task automatic begin_acc(input logic [15:0] l, input string nm);
        drive(1'b1, 1'b0, l, 1'b0);
        drive(1'b0, 1'b0, l, 1'b1);
        chk({nm, "_sync"}, 32'(bus.bl_sync), 32'd1);
        chk({nm, "_sync_en"}, 32'(bus.bl_en), 32'd0);
    endtask

    // Runs RUN cycles until a dump is seen; en_n=-1 on budget expiry.
    task automatic run_to_dump(input logic [15:0] l, input bit toggle,
                               input int stop_at, input int budget,
                               output int en_n, output int clk_n,
                               output int fl_bad);
        bit   found;
        logic v, p;
        en_n   = 0;
        clk_n  = 0;
        fl_bad = 0;
        found  = 1'b0;
        while (!found && clk_n < budget) begin
            v = toggle ? logic'(clk_n % 2 == 0) : 1'b1;
            p = v && (stop_at == en_n + 1);
            drive(1'b0, p, l, v);
            clk_n++;
            if (bus.bl_en) en_n++;
            if (!(bus.acc_first && bus.acc_last)) fl_bad++;
            if (bus.dump) found = 1'b1;
        end
        if (!found) en_n = -1;
    endtask

    initial begin
        int en_n, clk_n, bad;
        bit saw_dump;

        vt[0] = '{1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
        vt[5] = '{1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
        vt[6] = '{1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].start, vt[i].stop, vt[i].len, vt[i].vld);
            chk($sformatf("v%0d_sync", i),  32'(bus.bl_sync),   32'(vt[i].sync));
            chk($sformatf("v%0d_en", i),    32'(bus.bl_en),     32'(vt[i].en));
            chk($sformatf("v%0d_first", i), 32'(bus.acc_first), 32'(vt[i].first));
            chk($sformatf("v%0d_last", i),  32'(bus.acc_last),  32'(vt[i].last));
            chk($sformatf("v%0d_dump", i),  32'(bus.dump),      32'(vt[i].dump));
            chk($sformatf("v%0d_busy", i),  32'(bus.busy),      32'(vt[i].busy));
            chk($sformatf("v%0d_acc", i),   bus.acc_cnt,        vt[i].acc);
        end

        // acc_len=2, continuous data: dumps at enabled cycles 288 and 576
        do_reset();
        begin_acc(16'd2, "a");
        run_to_dump(16'd2, 1'b0, 0, 1000, en_n, clk_n, bad);
        chk("a_dump1_at", 32'(en_n), 32'd288);
        drive(1'b0, 1'b0, 16'd2, 1'b0);
        chk("a_acc1", bus.acc_cnt, 32'd1);
        chk("a_busy1", 32'(bus.busy), 32'd1);
        chk("a_stall_en", 32'(bus.bl_en), 32'd0);
        chk("a_first_after", 32'(bus.acc_first), 32'd1);
        run_to_dump(16'd2, 1'b0, 0, 1000, en_n, clk_n, bad);
        chk("a_dump2_at", 32'(en_n + 288), 32'd576);
        drive(1'b0, 1'b0, 16'd2, 1'b0);
        chk("a_acc2", bus.acc_cnt, 32'd2);

        // acc_len=1 with data_vld toggling
        do_reset();
        begin_acc(16'd1, "b");
        run_to_dump(16'd1, 1'b1, 0, 1000, en_n, clk_n, bad);
        chk("b_dump_en", 32'(en_n), 32'd144);
        chk("b_dump_clk", 32'(clk_n), 32'd287);
        chk("b_first_last", 32'(bad), 32'd0);
        drive(1'b0, 1'b0, 16'd1, 1'b0);
        chk("b_acc", bus.acc_cnt, 32'd1);

        // acc_len=3, stop at enabled cycle 10 ends at 432
        do_reset();
        begin_acc(16'd3, "c");
        run_to_dump(16'd3, 1'b0, 10, 1000, en_n, clk_n, bad);
        chk("c_dump_at", 32'(en_n), 32'd432);
        drive(1'b0, 1'b0, 16'd3, 1'b1);
        chk("c_busy", 32'(bus.busy), 32'd0);
        chk("c_acc", bus.acc_cnt, 32'd1);
        chk("c_en", 32'(bus.bl_en), 32'd0);
        drive(1'b0, 1'b1, 16'd3, 1'b1);
        drive(1'b0, 1'b0, 16'd3, 1'b1);
        chk("c_idle_stop", 32'(bus.busy), 32'd0);
        chk("c_acc_hold", bus.acc_cnt, 32'd1);

        // stop coincident with dump; start in RUN ignored
        do_reset();
        begin_acc(16'd1, "d");
        run_to_dump(16'd1, 1'b0, 0, 1000, en_n, clk_n, bad);
        chk("d_dump1_at", 32'(en_n), 32'd144);
        drive(1'b1, 1'b0, 16'd5, 1'b0);
        chk("d_run_start_busy", 32'(bus.busy), 32'd1);
        run_to_dump(16'd5, 1'b0, 144, 1000, en_n, clk_n, bad);
        chk("d_dump2_at", 32'(en_n), 32'd144);
        drive(1'b0, 1'b0, 16'd5, 1'b1);
        chk("d_busy", 32'(bus.busy), 32'd0);
        chk("d_acc", bus.acc_cnt, 32'd2);

        // async reset at enabled cycle 100, then acc_len=0 treated as 1
        do_reset();
        begin_acc(16'd2, "e");
        saw_dump = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b0, 16'd2, 1'b1);
            if (bus.dump) saw_dump = 1'b1;
        end
        chk("e_no_dump", 32'(saw_dump), 32'd0);
        chk("e_en_pre", 32'(bus.bl_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("e_rst_en", 32'(bus.bl_en), 32'd0);
        chk("e_rst_busy", 32'(bus.busy), 32'd0);
        chk("e_rst_first", 32'(bus.acc_first), 32'd0);
        chk("e_rst_dump", 32'(bus.dump), 32'd0);
        chk("e_rst_sync", 32'(bus.bl_sync), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk("e_idle_wait", 32'(bus.busy), 32'd0);
        begin_acc(16'd0, "e2");
        run_to_dump(16'd0, 1'b0, 0, 1000, en_n, clk_n, bad);
        chk("e_dump1_at", 32'(en_n), 32'd144);
        chk("e_len1_fl", 32'(bad), 32'd0);
        run_to_dump(16'd0, 1'b0, 0, 1000, en_n, clk_n, bad);
        chk("e_dump2_at", 32'(en_n), 32'd144);
        drive(1'b0, 1'b0, 16'd0, 1'b0);
        chk("e_acc", bus.acc_cnt, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
